// File: rtl/synt_ctrl_if.sv
// rtl/synt_ctrl_if.sv - control/status bundle between radio control, synt_ctrl and the synthesizer
interface synt_ctrl_if;
    logic       en;
    logic       recal;
    logic       rdy_synt;
    logic       pu_synt;
    logic       cal_synt;
    logic       locked;
    logic       busy;
    logic       err;
    logic [1:0] retry_cnt;

    modport master (
        output en, recal, rdy_synt,
        input  pu_synt, cal_synt, locked, busy, err, retry_cnt
    );

    modport slave (
        input  en, recal, rdy_synt,
        output pu_synt, cal_synt, locked, busy, err, retry_cnt
    );
endinterface

// File: rtl/synt_ctrl.sv
// rtl/synt_ctrl.sv - synthesizer power-up, calibration and retry sequencer
// Optional loss-of-lock monitor in LOCK: SYNT_CTRL_LOCKMON_EN
module synt_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int CAL_CYC     = 2,
    parameter int TIMEOUT_CYC = 2048,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    synt_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_CAL,
        S_WAIT_RDY,
        S_COOL,
        S_LOCK,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CAL_LD     = CNT_W'(CAL_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       retry, retry_nx;
    logic             cnt_zero;
    logic             rdy_m, rdy_s;
    logic             pu_q, cal_q, locked_q, busy_q, err_q;

    assign cnt_zero = (cnt == '0);

    // rdy_synt comes from the synthesizer clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= bus.rdy_synt;
            rdy_s <= rdy_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            retry    <= '0;
            pu_q     <= 1'b0;
            cal_q    <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            retry    <= retry_nx;
            pu_q     <= state_nx inside {S_PWRUP, S_CAL, S_WAIT_RDY, S_LOCK};
            cal_q    <= (state_nx == S_CAL);
            locked_q <= (state_nx == S_LOCK);
            busy_q   <= state_nx inside {S_PWRUP, S_CAL, S_WAIT_RDY, S_COOL};
            err_q    <= (state_nx == S_FAIL);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        retry_nx = retry;
        case (state)
            S_IDLE: begin
                if (bus.en) begin
                    state_nx = S_PWRUP;
                    cnt_nx   = SETTLE_LD;
                    retry_nx = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_zero) begin
                    state_nx = S_CAL;
                    cnt_nx   = CAL_LD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_CAL: begin
                if (cnt_zero) begin
                    state_nx = S_WAIT_RDY;
                    cnt_nx   = TIMEOUT_LD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_WAIT_RDY: begin
                // ready seen on the timeout cycle still counts as a lock
                if (rdy_s) begin
                    state_nx = S_LOCK;
                end else if (cnt_zero) begin
                    if (retry < RETRY_MAX) begin
                        state_nx = S_COOL;
                        cnt_nx   = SETTLE_LD;
                        retry_nx = retry + 2'd1;
                    end else begin
                        state_nx = S_FAIL;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_COOL: begin
                if (cnt_zero) begin
                    state_nx = S_PWRUP;
                    cnt_nx   = SETTLE_LD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_LOCK: begin
`ifdef SYNT_CTRL_LOCKMON_EN
                if (!rdy_s) begin
                    if (retry < RETRY_MAX) begin
                        state_nx = S_COOL;
                        cnt_nx   = SETTLE_LD;
                        retry_nx = retry + 2'd1;
                    end else begin
                        state_nx = S_FAIL;
                    end
                end else if (bus.recal) begin
                    state_nx = S_CAL;
                    cnt_nx   = CAL_LD;
                end
`else
                if (bus.recal) begin
                    state_nx = S_CAL;
                    cnt_nx   = CAL_LD;
                end
`endif
            end
            S_FAIL: begin
                state_nx = S_FAIL;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        // dropping the request overrides everything, including a pending calibration
        if (!bus.en) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            retry_nx = '0;
        end
    end

    assign bus.pu_synt   = pu_q;
    assign bus.cal_synt  = cal_q;
    assign bus.locked    = locked_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.retry_cnt = retry;
endmodule

// File: tb/tb_synt_ctrl.sv
// tb/tb_synt_ctrl.sv - randomized self-checking bench for synt_ctrl against a timeline model
`timescale 1ns/1ps
module tb_synt_ctrl;
    localparam int SETTLE = 16;
    localparam int CALW   = 2;
    localparam int TOUT   = 2048;
    localparam int MAXR   = 3;
    localparam int T_CAL  = SETTLE;
    localparam int T_WAIT = SETTLE + CALW;
    localparam int T_COOL = T_WAIT + TOUT;
    localparam int PERIOD = T_COOL + SETTLE;

    logic clk = 1'b0;
    logic rst;
    synt_ctrl_if bus();

    synt_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int rs, q, lk;
    int cal_rises;
    logic [6:0] dut_out;

    assign dut_out = {bus.pu_synt, bus.cal_synt, bus.locked, bus.busy, bus.err, bus.retry_cnt};

    // Edge offsets are counted from the edge that first samples en=1 (offset 0 enters power-up).
    // Each attempt spans PERIOD edges; ready is honoured on edges T_WAIT+1..T_COOL of an attempt.
    function automatic int lock_edge(input int r_s);
        if (r_s < 0) return -1;
        for (int k = r_s; k <= MAXR * PERIOD + T_COOL; k++) begin
            if ((k % PERIOD) > T_WAIT && (k % PERIOD) <= T_COOL) return k;
        end
        return -1;
    endfunction

    function automatic logic [6:0] exp_out(input int k);
        int a, r;
        logic pu, cal, lkd, bsy, er;
        logic [1:0] rc;
        pu = 0; cal = 0; lkd = 0; bsy = 0; er = 0; rc = 2'd0;
        if (lk >= 0 && k >= lk) begin
            rc = 2'(lk / PERIOD);
            pu = 1;
            if (q >= 0 && k >= q && k <= q + CALW) begin
                bsy = 1;
                cal = (k < q + CALW);
            end else begin
                lkd = 1;
            end
        end else begin
            a = k / PERIOD;
            r = k % PERIOD;
            if (a > MAXR || (a == MAXR && r >= T_COOL)) begin
                er = 1;
                rc = 2'(MAXR);
            end else begin
                bsy = 1;
                rc  = 2'(a);
                if (r < T_COOL) begin
                    pu  = 1;
                    cal = (r >= T_CAL && r < T_WAIT);
                end else begin
                    rc = 2'(a + 1);
                end
            end
        end
        return {pu, cal, lkd, bsy, er, rc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int rs_in, input int q_in, input int ncyc, input string name);
        logic [6:0] e;
        logic cal_prev;
        bit bad;
        rs = rs_in;
        q  = q_in;
        lk = lock_edge(rs_in);
        bad = 0;
        cal_rises = 0;
        cal_prev = 0;
        bus.en = 1'b1;
        for (int k = 0; k < ncyc && !bad; k++) begin
            tick();
            e = exp_out(k);
            checks++;
            if (dut_out !== e) begin
                $display("FAIL %s edge %0d: got {pu,cal,locked,busy,err,retry}=%b, expected %b", name, k, dut_out, e);
                bad = 1;
            end else begin
                passed++;
            end
            if (bus.cal_synt && !cal_prev) cal_rises++;
            cal_prev = bus.cal_synt;
            if (rs >= 0 && k == rs - 3) bus.rdy_synt = 1'b1;
            if (q >= 0 && k == q - 1) bus.recal = 1'b1;
            if (q >= 0 && k == q) bus.recal = 1'b0;
        end
    endtask

    task automatic stop_seq(input string name);
        bus.en = 1'b0;
        tick();
        checks++;
        if (dut_out !== 7'd0) $display("FAIL %s_en_drop: got %b, expected 0000000", name, dut_out);
        else passed++;
        bus.rdy_synt = 1'b0;
        bus.recal = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.recal = 1'b0;
        bus.rdy_synt = 1'b0;
        repeat (3) tick();
        checks++;
        if (dut_out !== 7'd0) $display("FAIL reset_state: got %b, expected 0000000", dut_out);
        else passed++;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_nominal();
        run_seq(T_WAIT + 100 + 3, -1, T_WAIT + 130, "nominal");
        stop_seq("nominal");
    endtask

    task automatic test_single_retry();
        run_seq(PERIOD + T_WAIT + 10 + 3, -1, PERIOD + T_WAIT + 40, "single_retry");
        checks++;
        if (cal_rises !== 2) $display("FAIL single_retry_cal_pulses: got %0d, expected 2", cal_rises);
        else passed++;
        stop_seq("single_retry");
    endtask

    task automatic test_exhaustion();
        run_seq(-1, -1, MAXR * PERIOD + T_COOL + 10, "exhaustion");
        checks++;
        if (cal_rises !== MAXR + 1) $display("FAIL exhaustion_cal_pulses: got %0d, expected %0d", cal_rises, MAXR + 1);
        else passed++;
        stop_seq("exhaustion");
    endtask

    task automatic test_abort();
        run_seq(-1, -1, T_CAL + 2, "abort_pre");
        bus.en = 1'b0;
        tick();
        checks++;
        if (dut_out !== 7'd0) $display("FAIL abort_in_cal: got %b, expected 0000000", dut_out);
        else passed++;
        tick();
        run_seq(-1, -1, T_WAIT + 5, "abort_restart");
        stop_seq("abort");
    endtask

    task automatic test_recal();
        int r_s, l;
        r_s = T_WAIT + 3 + $urandom_range(0, 300);
        l = lock_edge(r_s);
        run_seq(r_s, l + 2 + $urandom_range(0, 30), l + 45, "recal");
        checks++;
        if (cal_rises !== 2) $display("FAIL recal_cal_pulses: got %0d, expected 2", cal_rises);
        else passed++;
        stop_seq("recal");
    endtask

    task automatic test_async_reset();
        run_seq(-1, -1, T_WAIT + 50, "async_pre");
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_out !== 7'd0) $display("FAIL async_reset: got %b, expected 0000000", dut_out);
        else passed++;
        bus.en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_lockmon();
        bit bad;
        run_seq(T_WAIT + 10, -1, T_WAIT + 30, "lockmon_pre");
        bus.rdy_synt = 1'b0;
        bad = 0;
        for (int i = 1; i <= 40 && !bad; i++) begin
            tick();
`ifdef SYNT_CTRL_LOCKMON_EN
            if (i == 3 || i == 3 + SETTLE || i == 3 + 2 * SETTLE) begin
                logic [6:0] e;
                e = (i == 3) ? 7'b0001001 : (i == 3 + SETTLE) ? 7'b1001001 : 7'b1101001;
                checks++;
                if (dut_out !== e) begin
                    $display("FAIL lockmon_loss +%0d: got %b, expected %b", i, dut_out, e);
                    bad = 1;
                end else begin
                    passed++;
                end
            end
`else
            checks++;
            if (dut_out !== 7'b1010000) begin
                $display("FAIL lockmon_hold +%0d: got %b, expected 1010000", i, dut_out);
                bad = 1;
            end else begin
                passed++;
            end
`endif
        end
        stop_seq("lockmon");
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            int r_s, l;
            r_s = $urandom_range(3, 2 * PERIOD + T_COOL);
            l = lock_edge(r_s);
            run_seq(r_s, -1, l + 12, "random");
            stop_seq("random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_single_retry();
        test_exhaustion();
        test_abort();
        test_recal();
        test_async_reset();
        test_lockmon();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/synt_ctrl.md
Name: synt_ctrl

Overview:
Power-up and calibration sequencer for the frequency synthesizer block.
- On request it drives PU_SYNT, waits a settle time, pulses CAL_SYNT, then waits for RDY_SYNT.
- A missing RDY_SYNT triggers a power-cycle retry, up to a bounded count; exhausting the retries is reported as an error.
- Sits between the radio top-level control and the synthesizer; it is the only driver of PU_SYNT and CAL_SYNT.

Parameters:
- SETTLE_CYC, 16: cycles PU_SYNT is held high before calibration; also the forced-off time between retries.
- CAL_CYC, 2: width of the CAL_SYNT pulse in cycles (>=1).
- TIMEOUT_CYC, 2048: maximum WAIT_RDY cycles before a retry.
- MAX_RETRY, 3: number of retries after the first attempt.
- CNT_W, 16: width of the internal down-counter; must hold max(SETTLE_CYC, CAL_CYC, TIMEOUT_CYC).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  level request: 1 = synthesizer wanted on and locked.
- RECAL  in  1  single-cycle pulse: recalibrate while locked.
- RDY_SYNT  in  1  synthesizer ready; asynchronous to CLK.
- PU_SYNT  out  1  synthesizer power-up, registered.
- CAL_SYNT  out  1  calibration strobe, registered.
- LOCKED  out  1  synthesizer powered and ready.
- BUSY  out  1  sequence in progress (PWRUP/CAL/WAIT_RDY/COOL).
- ERR  out  1  retries exhausted, sticky until EN=0.
- RETRY_CNT  out  2  retries consumed in the current sequence.

Behaviour:
- Reset: one clock; asynchronous, active-high reset. RST=1 forces state IDLE, all outputs 0, counter 0, sync flops 0.
- RDY_SYNT passes through a 2-flop synchronizer (rdy_s), giving 2 cycles of latency. Only rdy_s is used internally.
- All outputs are registered and decoded from the next state, so an output changes on the same edge as the state transition.
- IDLE: all outputs 0. EN=1 -> PWRUP, counter=SETTLE_CYC-1, RETRY_CNT=0.
- PWRUP: PU_SYNT=1, BUSY=1. Counter decrements each cycle; at 0 -> CAL, counter=CAL_CYC-1.
- CAL: PU_SYNT=1, CAL_SYNT=1. At counter 0 -> WAIT_RDY, counter=TIMEOUT_CYC-1.
- WAIT_RDY: PU_SYNT=1, CAL_SYNT=0.
  - rdy_s=1 -> LOCK.
  - Counter at 0 with rdy_s=0 and RETRY_CNT<MAX_RETRY -> COOL, RETRY_CNT+1, counter=SETTLE_CYC-1.
  - Counter at 0 with rdy_s=0 and RETRY_CNT==MAX_RETRY -> FAIL.
  - If rdy_s=1 and the counter reaches 0 in the same cycle, LOCK wins.
- COOL: PU_SYNT=0, BUSY=1. At counter 0 -> PWRUP, counter=SETTLE_CYC-1. RETRY_CNT is held.
- LOCK: PU_SYNT=1, LOCKED=1, BUSY=0. RECAL=1 -> CAL, counter=CAL_CYC-1, LOCKED=0 on the same edge. RECAL does not reset RETRY_CNT.
- FAIL: PU_SYNT=0, ERR=1, BUSY=0. Held while EN=1.
- EN=0 in any state -> IDLE on the next edge, all outputs 0. This has priority over every other transition. A sequence aborted mid-operation does not pulse CAL_SYNT again.
- RECAL outside LOCK is ignored.
- RETRY_CNT saturates at MAX_RETRY and never wraps.
- The counter never underflows: every state that uses it reloads it on entry.

Optional Feature:
SYNT_CTRL_LOCKMON_EN.
- Defined: in LOCK, rdy_s=0 means loss of lock.
  - If RETRY_CNT<MAX_RETRY -> COOL with RETRY_CNT+1 and LOCKED=0 on the same edge.
  - Otherwise -> FAIL.
- Undefined: rdy_s is ignored in LOCK, and LOCKED stays 1 until EN=0 or RECAL.

Test Plan:
- Nominal lock (defaults):
  - Stimulus: EN 0->1; RDY_SYNT driven high 100 cycles after CAL_SYNT falls.
  - Required: PU_SYNT rises 1 cycle after EN is sampled and stays high. CAL_SYNT is high for exactly 2 cycles, starting 16 cycles after PU_SYNT rises. LOCKED rises 2-3 cycles after RDY_SYNT, RETRY_CNT=0, BUSY=0.
- Single retry:
  - Stimulus: RDY_SYNT held low for the first attempt, then asserted 10 cycles into the second WAIT_RDY.
  - Required: after 2048 WAIT_RDY cycles, PU_SYNT=0 for 16 cycles. A second CAL_SYNT pulse follows. LOCKED=1 with RETRY_CNT=1.
- Exhaustion:
  - Stimulus: RDY_SYNT always 0.
  - Required: 4 CAL_SYNT pulses in total, then ERR=1, PU_SYNT=0, RETRY_CNT=3. Dropping EN clears ERR on the next edge.
- Abort mid-operation:
  - Stimulus: EN=0 during the second cycle of CAL.
  - Required: on the next edge CAL_SYNT=0, PU_SYNT=0, BUSY=0, state IDLE. Reasserting EN restarts with RETRY_CNT=0.
- Recalibrate:
  - Stimulus: in LOCK, a 1-cycle RECAL pulse.
  - Required: LOCKED drops, PU_SYNT stays 1 throughout, one 2-cycle CAL_SYNT pulse. LOCKED returns after rdy_s=1.
  - Also: asserting RST mid-WAIT_RDY zeroes all outputs immediately, without waiting for a clock edge.
- Lock monitor (SYNT_CTRL_LOCKMON_EN defined):
  - Stimulus: RDY_SYNT drops while in LOCK.
  - Required: LOCKED falls and RETRY_CNT increments. The block goes through COOL, then PWRUP, then CAL.
  - Without the macro, LOCKED stays 1 for the same stimulus.
